// File: rtl/aes_round_key_add.sv
// AES-128 key schedule (one round key per cycle) plus AddRoundKey; result is registered, 1-cycle latency.
// Input stalls while the output is held and downstream is not ready; a key load preempts state acceptance.

module s_box (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

  // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
  always_comb begin
    x2   = gf_mul(data_i, data_i);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
    data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_round_key_add #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:128] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [1:128] state_in,
  input  logic [3:0]   round_in,
  input  logic         state_valid,
  output logic         state_ready,
  output logic [1:128] state_out,
  output logic [3:0]   round_out,
  output logic         round_err,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam logic [3:0] LAST_RND = 4'(ROUNDS);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} fsm_e;

  fsm_e         fsm_q;
  logic [3:0]   cnt_q;
  logic [127:0] rk_q [0:ROUNDS];
  logic [127:0] out_q;
  logic [3:0]   rnd_q;
  logic         err_q;
  logic         vld_q;

  logic [127:0] key_w, state_w;
  logic         key_hs, st_hs;

  assign key_w   = key_in;
  assign state_w = state_in;

  assign key_ready   = (fsm_q != EXPAND) && !vld_q;
  assign state_ready = (fsm_q == READY) && !key_valid && (!vld_q || out_ready);
  assign key_hs      = key_valid && key_ready;
  assign st_hs       = state_valid && state_ready;

  assign state_out = out_q;
  assign round_out = rnd_q;
  assign round_err = err_q;
  assign out_valid = vld_q;

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [127:0] prev_rk;
  logic [31:0]  rot_w, sub_w, tmp_w;
  logic [31:0]  w0_d, w1_d, w2_d, w3_d;
  logic [127:0] rk_nxt_d;

  // w0 sits in the top 32 bits; w3 (bits [31:0]) feeds RotWord/SubWord.
  assign prev_rk = rk_q[cnt_q - 4'd1];
  assign rot_w   = {prev_rk[23:0], prev_rk[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    s_box u_sbox (.data_i(rot_w[8*b +: 8]), .data_o(sub_w[8*b +: 8]));
  end

  assign tmp_w    = sub_w ^ {rcon(cnt_q), 24'h0};
  assign w0_d     = prev_rk[127:96] ^ tmp_w;
  assign w1_d     = prev_rk[95:64] ^ w0_d;
  assign w2_d     = prev_rk[63:32] ^ w1_d;
  assign w3_d     = prev_rk[31:0] ^ w2_d;
  assign rk_nxt_d = {w0_d, w1_d, w2_d, w3_d};

  // An out-of-range round selects a zero key, which passes the state through.
  logic         err_d;
  logic [127:0] sel_rk, out_d;
  assign err_d  = round_in > LAST_RND;
  assign sel_rk = err_d ? '0 : rk_q[round_in];
  assign out_d  = state_w ^ sel_rk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      for (int i = 0; i <= ROUNDS; i++) rk_q[i] <= '0;
    end else if (key_hs) begin
      rk_q[0] <= key_w;
      cnt_q   <= 4'd1;
      fsm_q   <= EXPAND;
    end else if (fsm_q == EXPAND) begin
      rk_q[cnt_q] <= rk_nxt_d;
      if (cnt_q == LAST_RND) fsm_q <= READY;
      else                   cnt_q <= cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      rnd_q <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (st_hs) begin
      out_q <= out_d;
      rnd_q <= round_in;
      err_q <= err_d;
      vld_q <= 1'b1;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_aes_round_key_add.sv
// Vector table, streaming scoreboard and reset/collision sequences for aes_round_key_add.
module tb_aes_round_key_add;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] state_in;
  logic [3:0]   round_in;
  logic         state_valid;
  logic         state_ready;
  logic [127:0] state_out;
  logic [3:0]   round_out;
  logic         round_err;
  logic         out_valid;
  logic         out_ready;

  aes_round_key_add #(.ROUNDS(10)) dut (
    .clk(clk), .rst(rst),
    .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .state_in(state_in), .round_in(round_in), .state_valid(state_valid),
    .state_ready(state_ready), .state_out(state_out), .round_out(round_out),
    .round_err(round_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sb [256];
  logic [127:0] rk_m [11];

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ c[b];
      sb[x] = s;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = ref_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 11; n++) rk_m[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endtask

  function automatic logic [127:0] ref_out(input logic [127:0] st, input logic [3:0] r);
    return (r > 4'd10) ? st : (st ^ rk_m[r]);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  typedef struct {
    logic [127:0] st;
    logic [3:0]   rnd;
    logic [127:0] exp_st;
    logic [3:0]   exp_rnd;
    logic         exp_err;
  } vec_t;

  // ---------------- driver tasks ----------------
  task automatic load_key(input logic [127:0] k, output int lows, output logic sr_seen);
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    lows = 0;
    sr_seen = 1'b0;
    while (!key_ready && lows < 40) begin
      sr_seen |= state_ready;
      lows++;
      @(negedge clk);
    end
  endtask

  task automatic send_chk(input string name, input vec_t v);
    int waits;
    @(negedge clk);
    state_in = v.st;
    round_in = v.rnd;
    state_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    waits = 0;
    while (!state_ready && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    chk({name, "_accept_wait"}, 128'(waits < 20), 128'd1);
    @(posedge clk);
    @(negedge clk);
    state_valid = 1'b0;
    chk({name, "_vld"}, 128'(out_valid), 128'd1);
    chk({name, "_out"}, state_out, v.exp_st);
    chk({name, "_rnd"}, 128'(round_out), 128'(v.exp_rnd));
    chk({name, "_err"}, 128'(round_err), 128'(v.exp_err));
  endtask

  task automatic stream(input int ncyc, input bit rnd_ready);
    vec_t         q[$];
    vec_t         e;
    logic [127:0] cur_st, h_st;
    logic [3:0]   cur_rnd;
    logic [5:0]   h_ctl;
    logic         stalled, hs;
    int           sent, got, hs_cnt;
    cur_st = rand128();
    cur_rnd = 4'($urandom_range(0, 15));
    stalled = 1'b0;
    hs = 1'b0;
    sent = 0; got = 0; hs_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (hs) begin
        cur_st = rand128();
        cur_rnd = 4'($urandom_range(0, 15));
      end
      state_in = cur_st;
      round_in = cur_rnd;
      state_valid = 1'b1;
      if (stalled) begin
        chk("stall_hold_data", state_out, h_st);
        chk("stall_hold_ctl", 128'({out_valid, round_out, round_err}), 128'(h_ctl));
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_spurious_word", 128'd1, 128'd0);
        end else begin
          e = q.pop_front();
          chk("stream_out", state_out, e.exp_st);
          chk("stream_rnd_err", 128'({round_out, round_err}), 128'({e.exp_rnd, e.exp_err}));
          got++;
        end
      end
      stalled = out_valid && !out_ready;
      h_st = state_out;
      h_ctl = {out_valid, round_out, round_err};
      hs = state_ready;
      if (hs) begin
        q.push_back('{cur_st, cur_rnd, ref_out(cur_st, cur_rnd), cur_rnd, cur_rnd > 4'd10});
        sent++;
        hs_cnt++;
      end
    end
    @(negedge clk);
    state_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 4 && q.size() > 0; c++) begin
      if (out_valid) begin
        e = q.pop_front();
        chk("drain_out", state_out, e.exp_st);
        got++;
      end
      @(negedge clk);
      #1;
    end
    chk("stream_count", 128'(got), 128'(sent));
    if (!rnd_ready) chk("full_rate", 128'(hs_cnt), 128'(ncyc));
  endtask

  // ---------------- test sequence ----------------
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    vec_t         vt[12];
    vec_t         v;
    logic [127:0] k2, s;
    logic [3:0]   r;
    int           lows;
    logic         sr_seen;

    rst = 1'b1;
    key_in = '0; key_valid = 1'b0;
    state_in = '0; round_in = '0; state_valid = 1'b0;
    out_ready = 1'b1;
    build_sbox();
    expand(K1);
    #12;
    chk("rst_key_ready", 128'(key_ready), 128'd1);
    chk("rst_state_ready", 128'(state_ready), 128'd0);
    chk("rst_outputs", 128'({out_valid, round_out, round_err}), 128'd0);
    chk("rst_state_out", state_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    load_key(K1, lows, sr_seen);
    chk("expand_cycles", 128'(lows), 128'd10);
    chk("no_ready_in_expand", 128'(sr_seen), 128'd0);
    chk("ready_after_expand", 128'(state_ready), 128'd1);

    vt[0] = '{128'h0, 4'd1, RK1, 4'd1, 1'b0};
    vt[1] = '{128'h0, 4'd10, RK10, 4'd10, 1'b0};
    vt[2] = '{128'h046681e5e0cb199a48f8d37a2806264c, 4'd1,
              128'ha49c7ff2689f352b6b5bea43026a5049, 4'd1, 1'b0};
    vt[3] = '{128'h0, 4'd12, 128'h0, 4'd12, 1'b1};
    vt[4] = '{{128{1'b1}}, 4'd15, {128{1'b1}}, 4'd15, 1'b1};
    vt[5] = '{128'h0, 4'd0, K1, 4'd0, 1'b0};
    vt[6] = '{128'h5a5a, 4'd11, 128'h5a5a, 4'd11, 1'b1};
    for (int i = 7; i < 12; i++) begin
      s = rand128();
      r = 4'($urandom_range(0, 15));
      vt[i] = '{s, r, ref_out(s, r), r, r > 4'd10};
    end
    for (int i = 0; i < 12; i++) send_chk($sformatf("vec%0d", i), vt[i]);

    stream(200, 1'b1);
    stream(30, 1'b0);

    // Key and state offered together in READY: key wins.
    k2 = rand128();
    @(negedge clk);
    key_in = k2; key_valid = 1'b1;
    state_in = rand128(); round_in = 4'd1; state_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("coll_key_ready", 128'(key_ready), 128'd1);
    chk("coll_state_ready", 128'(state_ready), 128'd0);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0; state_valid = 1'b0;
    chk("coll_no_output", 128'(out_valid), 128'd0);
    lows = 0;
    while (!key_ready && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    chk("coll_expand_cycles", 128'(lows), 128'd10);
    expand(k2);
    for (int i = 0; i < 3; i++) begin
      s = rand128();
      r = (i == 0) ? 4'd10 : 4'($urandom_range(0, 10));
      v = '{s, r, ref_out(s, r), r, 1'b0};
      send_chk($sformatf("k2_vec%0d", i), v);
    end

    // Reset during the 5th EXPAND cycle.
    expand(K1);
    @(negedge clk);
    key_in = K1; key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 128'(key_ready), 128'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", 128'({out_valid, round_out, round_err}), 128'd0);
    chk("mid_rst_state_out", state_out, 128'd0);
    chk("mid_rst_key_ready", 128'(key_ready), 128'd1);
    chk("mid_rst_state_ready", 128'(state_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_idle", 128'({key_ready, state_ready}), 128'b10);
    load_key(K1, lows, sr_seen);
    chk("reload_expand_cycles", 128'(lows), 128'd10);
    send_chk("reload_rk1", vt[0]);
    send_chk("reload_rk10", vt[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/aes_round_key_add.md
AES_ROUND_KEY_ADD -- requirements
Module: aes_round_key_add

Interface
REQ-001 SHALL have parameter ROUNDS, default 10, meaning the number of AES-128 rounds; only the value 10 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port key_in, input, [1:128]: cipher key.
REQ-005 SHALL have port key_valid, input, 1 bit: key_in is valid.
REQ-006 SHALL have port key_ready, output, 1 bit: the block can accept a key.
REQ-007 SHALL have port state_in, input, [1:128]: state word from the MixColumns stage.
REQ-008 SHALL have port round_in, input, [3:0]: index of the round key to apply.
REQ-009 SHALL have port state_valid, input, 1 bit: state_in and round_in are valid.
REQ-010 SHALL have port state_ready, output, 1 bit: the block can accept a state word.
REQ-011 SHALL have port state_out, output, [1:128]: registered result.
REQ-012 SHALL have port round_out, output, [3:0]: round index of state_out.
REQ-013 SHALL have port round_err, output, 1 bit: round_in was greater than 10 for the word currently held in state_out.
REQ-014 SHALL have port out_valid, output, 1 bit: state_out is valid.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts state_out.

Function
REQ-016 SHALL use this bit order on every 128-bit bus: byte k occupies bits [8k+1:8k+8]; bytes are column-major; word w0 = [1:32] and w3 = [97:128].
REQ-017 SHALL implement the FSM states IDLE, EXPAND and READY; reset enters IDLE.
REQ-018 SHALL define a key handshake as key_valid and key_ready high on the same edge.
REQ-019 SHALL drive key_ready = (state != EXPAND) and not out_valid.
REQ-020 SHALL, on a key handshake, store key_in as rk[0], set the round counter to 1 and enter EXPAND from any state; this discards any previous schedule.
REQ-021 SHALL, in EXPAND, compute one round key per cycle: rk[n] from rk[n-1].
REQ-022 SHALL compute each round key as follows: temp = SubWord(RotWord(w3)) xor {Rcon[n],00,00,00}; w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-023 SHALL define RotWord as b0b1b2b3 -> b1b2b3b0.
REQ-024 SHALL perform the four S-box lookups combinationally through the team's existing s_box byte-substitution module (8 bits in, 8 bits out).
REQ-025 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
REQ-026 SHALL, after rk[10] is written, which takes exactly 10 EXPAND cycles, enter READY; the counter does not wrap.
REQ-027 SHALL store the 11 round keys in registers.
REQ-028 SHALL drive state_ready = (state == READY) and not key_valid and (not out_valid or out_ready); key load has priority over state acceptance.
REQ-029 SHALL, on a state handshake (state_valid and state_ready), register state_out = state_in xor rk[round_in] and round_out = round_in, and set out_valid on the next edge; latency is 1 cycle.
REQ-030 SHALL, when round_in > 10, register state_out = state_in unchanged with round_err = 1; otherwise round_err = 0.
REQ-031 SHALL hold out_valid, state_out, round_out and round_err stable until out_ready is high.
REQ-032 SHALL clear out_valid on an edge where out_ready is high and no new handshake occurs.
REQ-033 SHALL, when out_ready is high and a new handshake occurs on the same edge, replace the output word with no bubble, giving full throughput of 1 word per cycle.
REQ-034 SHALL keep state_ready at 0 in IDLE and EXPAND, so no word is combined with an incomplete schedule.

Reset
REQ-035 SHALL, while rst is high, asynchronously force state = IDLE, counter = 0, all rk = 0, state_out = 0, round_out = 0, round_err = 0 and out_valid = 0.
REQ-036 SHALL, after reset, present key_ready = 1 and state_ready = 0.
REQ-037 SHALL, when rst is asserted mid-EXPAND or while an output is pending, abandon the operation, drop the pending output and require a new key load.

Verification
REQ-038 SHALL cover: load key 2b7e151628aed2a6abf7158809cf4f3c -> key_ready low for 10 cycles, then READY; rk1 = a0fafe1788542cb123a339392a6c7605 and rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-039 SHALL cover: with that key, state_in 046681e5e0cb199a48f8d37a2806264c and round_in 1 -> one cycle later state_out a49c7ff2689f352b6b5bea43026a5049, round_out 1.
REQ-040 SHALL cover: state_in all zeros with round_in 10 -> state_out = rk10; with round_in 12 -> state_out = state_in and round_err = 1.
REQ-041 SHALL cover: state_valid held high and out_ready toggled randomly -> no word lost or duplicated, output stable while stalled, 1 word per cycle when out_ready stays high.
REQ-042 SHALL cover: key_valid and state_valid high together in READY -> key accepted, state not accepted, EXPAND restarts with the new key.
REQ-043 SHALL cover: rst pulsed on the 5th EXPAND cycle -> all outputs 0, state IDLE, key_ready 1; reloading the key reproduces REQ-038.
